// File: rtl/vga_sched_pkg.sv
// Shared types and index arithmetic for the VGA pattern scheduler.
package vga_sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StPause
  } sched_state_e;

  typedef enum logic [1:0] {
    ReqNone,
    ReqNext,
    ReqPrev
  } req_e;

  // Step a pattern index by one in the requested direction, wrapping inside 0..num_pat-1.
  function automatic int unsigned pat_step(input int unsigned idx, input req_e req,
                                           input int unsigned num_pat);
    int unsigned res;
    res = idx;
    case (req)
      ReqNext: res = (idx == num_pat - 32'd1) ? 32'd0 : idx + 32'd1;
      ReqPrev: res = (idx == 32'd0) ? num_pat - 32'd1 : idx - 32'd1;
      default: res = idx;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/vga_frame_tick.sv
// Frame-start detector: registers vsync, normalises its polarity and emits a one-cycle
// frame_tick on each inactive->active transition; also keeps the free-running frame count.
module vga_frame_tick #(
  parameter int unsigned VS_ACTIVE_LOW = 1,
  parameter int unsigned FCNT_W        = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_vsync,
  output logic              o_frame_tick,
  output logic [FCNT_W-1:0] o_frame_cnt
);

  logic              w_vs_act;
  logic              r_vs_act;
  logic              r_vs_prev;
  logic [FCNT_W-1:0] r_fcnt;

  assign w_vs_act = (VS_ACTIVE_LOW != 0) ? ~i_vsync : i_vsync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vs_act  <= 1'b0;
      r_vs_prev <= 1'b0;
      r_fcnt    <= '0;
    end else begin
      r_vs_act  <= w_vs_act;
      r_vs_prev <= r_vs_act;
      if (o_frame_tick) begin
        r_fcnt <= r_fcnt + FCNT_W'(1);
      end
    end
  end

  assign o_frame_tick = r_vs_act & ~r_vs_prev;
  assign o_frame_cnt  = r_fcnt;

endmodule

// File: rtl/vga_pattern_sched.sv
// Frame-synchronous test-pattern scheduler: auto-advance, next/prev/pause keys, all changes
// applied at frame boundaries. Define VGA_SCHED_BLANK_EN to insert a blank frame before each change.
module vga_pattern_sched
  import vga_sched_pkg::*;
#(
  parameter int unsigned NUM_PAT       = 8,
  parameter int unsigned PAT_W         = 3,
  parameter int unsigned DWELL_FRAMES  = 120,
  parameter int unsigned VS_ACTIVE_LOW = 1,
  parameter int unsigned FCNT_W        = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_vsync,
  input  logic              i_key_next,
  input  logic              i_key_prev,
  input  logic              i_key_pause,
  output logic [PAT_W-1:0]  o_pattern_sel,
  output logic              o_pat_update,
  output logic              o_paused,
  output logic              o_sched_active,
  output logic              o_pattern_blank,
  output logic [FCNT_W-1:0] o_frame_cnt
);

  localparam int unsigned DWELL_W = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;

  logic               w_tick;
  sched_state_e       r_state, w_state_nxt;
  logic [PAT_W-1:0]   r_sel, w_sel_nxt, w_tgt;
  logic               r_upd, w_upd_nxt;
  logic               r_paused, w_paused_nxt;
  logic               r_active, w_active_nxt;
  logic [DWELL_W-1:0] r_dwell, w_dwell_nxt;
  req_e               r_pend, w_pend_nxt;
  logic               w_change;

  vga_frame_tick #(
    .VS_ACTIVE_LOW (VS_ACTIVE_LOW),
    .FCNT_W        (FCNT_W)
  ) u_frame_tick (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_vsync      (i_vsync),
    .o_frame_tick (w_tick),
    .o_frame_cnt  (o_frame_cnt)
  );

`ifdef VGA_SCHED_BLANK_EN
  logic             r_blank, w_blank_nxt;
  logic [PAT_W-1:0] r_tgt, w_tgt_nxt;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_sel_nxt    = r_sel;
    w_upd_nxt    = 1'b0;
    w_paused_nxt = r_paused;
    w_active_nxt = r_active;
    w_dwell_nxt  = r_dwell;
    w_pend_nxt   = r_pend;
    w_change     = 1'b0;
    w_tgt        = r_sel;
`ifdef VGA_SCHED_BLANK_EN
    w_blank_nxt  = r_blank;
    w_tgt_nxt    = r_tgt;
`endif

    if (r_state != StIdle && i_key_pause) begin
      w_paused_nxt = ~r_paused;
    end

    case (r_state)
      StIdle: begin
        // First boundary only arms the scheduler; latched requests wait for the next one.
        if (w_tick) begin
          w_state_nxt  = StRun;
          w_active_nxt = 1'b1;
          w_upd_nxt    = 1'b1;
        end
      end
      StRun, StPause: begin
        if (w_tick) begin
`ifdef VGA_SCHED_BLANK_EN
          if (r_blank) begin
            w_sel_nxt   = r_tgt;
            w_upd_nxt   = 1'b1;
            w_blank_nxt = 1'b0;
          end else
`endif
          if (r_pend != ReqNone) begin
            w_tgt      = PAT_W'(pat_step(32'(r_sel), r_pend, NUM_PAT));
            w_change   = 1'b1;
            w_pend_nxt = ReqNone;
            if (r_state == StRun) begin
              w_dwell_nxt = '0;
            end
          end else if (r_state == StRun) begin
            if (r_dwell == DWELL_W'(DWELL_FRAMES - 1)) begin
              w_tgt       = PAT_W'(pat_step(32'(r_sel), ReqNext, NUM_PAT));
              w_change    = 1'b1;
              w_dwell_nxt = '0;
            end else begin
              w_dwell_nxt = r_dwell + DWELL_W'(1);
            end
          end
        end
        w_state_nxt = w_paused_nxt ? StPause : StRun;
      end
      default: w_state_nxt = StIdle;
    endcase

    // A key in the tick cycle lands after the tick has consumed pending.
    if (i_key_next ^ i_key_prev) begin
      w_pend_nxt = i_key_next ? ReqNext : ReqPrev;
    end

    if (w_change) begin
`ifdef VGA_SCHED_BLANK_EN
      w_blank_nxt = 1'b1;
      w_tgt_nxt   = w_tgt;
`else
      w_sel_nxt   = w_tgt;
      w_upd_nxt   = 1'b1;
`endif
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= StIdle;
      r_sel    <= '0;
      r_upd    <= 1'b0;
      r_paused <= 1'b0;
      r_active <= 1'b0;
      r_dwell  <= '0;
      r_pend   <= ReqNone;
    end else begin
      r_state  <= w_state_nxt;
      r_sel    <= w_sel_nxt;
      r_upd    <= w_upd_nxt;
      r_paused <= w_paused_nxt;
      r_active <= w_active_nxt;
      r_dwell  <= w_dwell_nxt;
      r_pend   <= w_pend_nxt;
    end
  end

`ifdef VGA_SCHED_BLANK_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_blank <= 1'b0;
      r_tgt   <= '0;
    end else begin
      r_blank <= w_blank_nxt;
      r_tgt   <= w_tgt_nxt;
    end
  end

  assign o_pattern_blank = r_blank;
`else
  assign o_pattern_blank = 1'b0;
`endif

  assign o_pattern_sel  = r_sel;
  assign o_pat_update   = r_upd;
  assign o_paused       = r_paused;
  assign o_sched_active = r_active;

endmodule

// File: tb/tb_vga_pattern_sched.sv
// Scoreboard bench for vga_pattern_sched: a frame-level model predicts every pat_update pulse
// and end-of-frame status; a negedge monitor compares them against the DUT.
module tb_vga_pattern_sched;

  localparam int unsigned NUM_PAT = 8;
  localparam int unsigned PAT_W   = 3;
  localparam int unsigned DWELL   = 3;
  localparam int unsigned FCNT_W  = 16;
  localparam logic        VS_ON   = 1'b0;
  localparam logic        VS_OFF  = 1'b1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              vsync = VS_OFF;
  logic              k_next = 1'b0;
  logic              k_prev = 1'b0;
  logic              k_pause = 1'b0;
  logic [PAT_W-1:0]  sel;
  logic              upd;
  logic              paused;
  logic              active;
  logic              blank;
  logic [FCNT_W-1:0] fcnt;

  vga_pattern_sched #(
    .NUM_PAT       (NUM_PAT),
    .PAT_W         (PAT_W),
    .DWELL_FRAMES  (DWELL),
    .VS_ACTIVE_LOW (1),
    .FCNT_W        (FCNT_W)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_vsync         (vsync),
    .i_key_next      (k_next),
    .i_key_prev      (k_prev),
    .i_key_pause     (k_pause),
    .o_pattern_sel   (sel),
    .o_pat_update    (upd),
    .o_paused        (paused),
    .o_sched_active  (active),
    .o_pattern_blank (blank),
    .o_frame_cnt     (fcnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int sel;
    int fcnt;
  } upd_t;

  typedef struct {
    int cyc;
    int sel;
    bit paused;
    bit active;
    bit blank;
    int fcnt;
  } st_t;

  upd_t upd_q[$];
  st_t  st_q[$];
  bit   done = 1'b0;
  int   n_checks = 0;
  int   n_err = 0;

  // Frame-level reference model
  int m_sel, m_dwell, m_fcnt, m_tgt, m_pend;  // m_pend: 0 none, 1 next, 2 prev
  bit m_paused, m_active, m_blank;

  function automatic void model_reset();
    m_sel = 0; m_dwell = 0; m_fcnt = 0; m_tgt = 0; m_pend = 0;
    m_paused = 1'b0; m_active = 1'b0; m_blank = 1'b0;
  endfunction

  function automatic void push_upd(input int due);
    upd_t u;
    u.cyc = due; u.sel = m_sel; u.fcnt = m_fcnt;
    upd_q.push_back(u);
  endfunction

  function automatic void push_st(input int at);
    st_t s;
    s.cyc = at; s.sel = m_sel; s.paused = m_paused; s.active = m_active;
    s.blank = m_blank; s.fcnt = m_fcnt;
    st_q.push_back(s);
  endfunction

  function automatic void model_change(input int tgt, input int due);
`ifdef VGA_SCHED_BLANK_EN
    m_blank = 1'b1;
    m_tgt   = tgt;
`else
    m_sel = tgt;
    push_upd(due);
`endif
  endfunction

  function automatic void model_tick(input int due);
    m_fcnt = (m_fcnt + 1) % (1 << FCNT_W);
    if (!m_active) begin
      m_active = 1'b1;
      push_upd(due);
    end
`ifdef VGA_SCHED_BLANK_EN
    else if (m_blank) begin
      m_blank = 1'b0;
      m_sel   = m_tgt;
      push_upd(due);
    end
`endif
    else if (m_pend != 0) begin
      model_change((m_pend == 1) ? (m_sel + 1) % NUM_PAT : (m_sel + NUM_PAT - 1) % NUM_PAT, due);
      m_pend = 0;
      if (!m_paused) m_dwell = 0;
    end else if (!m_paused) begin
      m_dwell++;
      if (m_dwell == DWELL) begin
        m_dwell = 0;
        model_change((m_sel + 1) % NUM_PAT, due);
      end
    end
  endfunction

  function automatic void model_key(input bit n, input bit p, input bit z);
    if (n != p) m_pend = n ? 1 : 2;
    if (z && m_active) m_paused = !m_paused;
  endfunction

  // One frame (or an idle stretch when vs_en=0); inj = {next,prev,pause} at cycle inj_c.
  task automatic run_frame(input int len, input bit vs_en, input bit rnd, input int inj_c,
                           input logic [2:0] inj, input int rst_c);
    logic [2:0] k;
    for (int c = 0; c < len; c++) begin
      @(posedge clk); #1;
      rst   = 1'b0;
      vsync = (vs_en && c < 3) ? VS_ON : VS_OFF;
      if (vs_en && c == 1) model_tick(cyc + 1);
      if (c == len - 1) push_st(cyc);
      k = 3'b000;
      if (c == inj_c) k = inj;
      else if (rnd && c >= 2 && c <= len - 2 && $urandom_range(7) == 0) k = 3'($urandom_range(7));
      if (c == rst_c) begin
        rst = 1'b1;
        k   = 3'b000;
        model_reset();
        push_st(cyc);
      end
      {k_next, k_prev, k_pause} = k;
      model_key(k[2], k[1], k[0]);
    end
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    run_frame(7, 1'b0, 1'b0, 4, 3'b100, -1);     // key_next latched while idle
    run_frame(16, 1'b1, 1'b0, -1, 3'b000, -1);   // IDLE -> RUN, pending kept
    run_frame(16, 1'b1, 1'b0, -1, 3'b000, -1);   // pending NEXT applied
    for (int f = 0; f < 7; f++) run_frame(14, 1'b1, 1'b0, -1, 3'b000, -1);
    run_frame(14, 1'b1, 1'b0, 6, 3'b010, -1);    // key_prev mid-frame
    run_frame(14, 1'b1, 1'b0, 6, 3'b110, -1);    // next+prev together: ignored
    run_frame(14, 1'b1, 1'b0, 6, 3'b001, -1);    // pause
    for (int f = 0; f < 10; f++) run_frame(12, 1'b1, 1'b0, -1, 3'b000, -1);
    run_frame(12, 1'b1, 1'b0, 5, 3'b100, -1);    // next while paused
    run_frame(12, 1'b1, 1'b0, 5, 3'b001, -1);    // resume
    run_frame(12, 1'b1, 1'b0, 1, 3'b100, -1);    // key in tick cycle: deferred
    run_frame(12, 1'b1, 1'b0, -1, 3'b000, -1);
    for (int f = 0; f < 40; f++) run_frame(int'($urandom_range(20, 10)), 1'b1, 1'b1, -1, 3'b000, -1);
    run_frame(16, 1'b1, 1'b0, 6, 3'b100, 8);     // reset mid-frame with NEXT pending
    run_frame(12, 1'b0, 1'b0, -1, 3'b000, -1);   // still idle after reset
    for (int f = 0; f < 6; f++) run_frame(int'($urandom_range(20, 10)), 1'b1, 1'b1, -1, 3'b000, -1);
    repeat (4) @(posedge clk);
    #1 done = 1'b1;
  end

  upd_t u;
  st_t  s;

  always @(negedge clk) begin
    if (upd) begin
      n_checks++;
      if (upd_q.size() == 0) begin
        n_err++;
        $display("FAIL pat_update: unexpected pulse at cycle %0d, sel=%0d", cyc, sel);
      end else begin
        u = upd_q.pop_front();
        if (u.cyc != cyc || u.sel != int'(sel) || u.fcnt != int'(fcnt)) begin
          n_err++;
          $display("FAIL pat_update: got cycle %0d sel %0d fcnt %0d, want cycle %0d sel %0d fcnt %0d",
                   cyc, sel, fcnt, u.cyc, u.sel, u.fcnt);
        end
      end
    end else if (upd_q.size() > 0 && upd_q[0].cyc <= cyc) begin
      u = upd_q.pop_front();
      n_checks++;
      n_err++;
      $display("FAIL pat_update: no pulse at cycle %0d, want sel %0d fcnt %0d", u.cyc, u.sel, u.fcnt);
    end
    while (st_q.size() > 0 && st_q[0].cyc <= cyc) begin
      s = st_q.pop_front();
      n_checks++;
      if (s.sel != int'(sel) || s.paused != paused || s.active != active ||
          s.blank != blank || s.fcnt != int'(fcnt)) begin
        n_err++;
        $display("FAIL status @%0d: got sel %0d paused %0b active %0b blank %0b fcnt %0d, want sel %0d paused %0b active %0b blank %0b fcnt %0d",
                 cyc, sel, paused, active, blank, fcnt,
                 s.sel, s.paused, s.active, s.blank, s.fcnt);
      end
    end
    if (done || cyc > 60000) begin
      n_checks++;
      if (!done || upd_q.size() != 0 || st_q.size() != 0) begin
        n_err++;
        $display("FAIL drain: done=%0b, %0d updates and %0d status checks outstanding, want 0",
                 done, upd_q.size(), st_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
    end
  end

endmodule

// File: doc/vga_pattern_sched.md
Name: vga_pattern_sched

Overview:
- Frame-synchronous scheduler that sequences the test-pattern generator feeding the VGA driver.
- Detects frame starts from the driver's vsync and auto-cycles the pattern index every DWELL_FRAMES frames.
- Accepts next/prev/pause requests and applies every change only at a frame boundary, so there is no mid-frame tearing.
- Runs in the pixel-clock domain, between the key debouncer and the pattern generator's select input.

Parameters:
- NUM_PAT, 8, number of patterns; legal range 2..2^PAT_W.
- PAT_W, 3, width of the pattern index.
- DWELL_FRAMES, 120, frames per pattern in auto mode; must be >=1.
- VS_ACTIVE_LOW, 1, 1 = vsync sync pulse is low, 0 = high.
- FCNT_W, 16, width of the free-running frame counter.

Ports:
- clk  in  1  pixel clock, same clock as the driver's vsync.
- rst  in  1  reset; asynchronous, active-high.
- vsync  in  1  vertical sync from the VGA driver, same clock domain.
- key_next  in  1  single-cycle request: next pattern.
- key_prev  in  1  single-cycle request: previous pattern.
- key_pause  in  1  single-cycle request: toggle auto-advance.
- pattern_sel  out  PAT_W  pattern index to the generator.
- pat_update  out  1  one-cycle pulse when pattern_sel changes.
- paused  out  1  auto-advance frozen.
- sched_active  out  1  low until the first frame boundary after reset.
- pattern_blank  out  1  blank-frame request (see Optional Feature).
- frame_cnt  out  FCNT_W  frames since reset; wraps.

Behaviour:
- Reset values (asynchronous, immediate, also mid-operation): pattern_sel=0, pat_update=0, paused=0, sched_active=0, pattern_blank=0, frame_cnt=0, dwell counter=0, pending=NONE, state=IDLE.
- Frame tick:
  - vsync is registered once.
  - frame_tick is an internal one-cycle pulse in the cycle after the first sample where vsync is at its active level and the previous sample was not.
  - If vsync is first sampled active in cycle N, frame_tick is high in N+1.
  - frame_cnt increments on each frame_tick and wraps.
- Pending request register holds NONE, NEXT or PREV:
  - key_next alone sets NEXT; key_prev alone sets PREV.
  - The latest request overwrites any earlier one.
  - key_next and key_prev high in the same cycle leave pending unchanged.
- Pause: key_pause toggles paused on the next clock edge in any state except IDLE; it is ignored in IDLE.
- FSM states: IDLE, RUN, PAUSE.
- IDLE:
  - On frame_tick: go to RUN, sched_active=1, pat_update pulses, pattern_sel stays 0.
  - Requests arriving in IDLE are latched and applied at the second frame_tick.
- RUN, on frame_tick, in priority order:
  1. pending != NONE: apply it, clear pending, reset the dwell counter to 0.
  2. Otherwise, if dwell == DWELL_FRAMES-1: advance +1 and reset dwell to 0.
  3. Otherwise: dwell+1.
- PAUSE: the dwell counter is frozen. Pending requests are still applied on frame_tick; the dwell counter is not reset.
- RUN<->PAUSE follows the paused flag.
- Index arithmetic: +1 from NUM_PAT-1 wraps to 0; -1 from 0 wraps to NUM_PAT-1. Values >= NUM_PAT are never produced.
- Latency: vsync active sampled in cycle N gives frame_tick in N+1; pattern_sel is new and pat_update=1 in N+2 for exactly one cycle.
- pat_update pulses only when a change is applied, or on the IDLE->RUN transition.
- A request arriving in the same cycle as frame_tick is not applied at that tick. It is latched and applied at the following frame_tick.

Optional Feature:
- Macro: VGA_SCHED_BLANK_EN.
- Defined:
  - A change decided at frame_tick is not applied immediately. Instead pattern_blank=1 from N+2 for one full frame, and pattern_sel holds its old value.
  - At the next frame_tick the change is applied (pat_update pulses) and pattern_blank returns to 0 in the same cycle.
  - Requests arriving during the blank frame stay pending. Such a request is applied at the first frame_tick after the blank frame ends, again preceded by its own blank frame.
  - The dwell counter does not count the blank frame.
- Not defined: pattern_blank is tied 0 and changes apply as described in Behaviour.

Decomposition:
- Package vga_sched_pkg holds:
  - the FSM state enum (IDLE/RUN/PAUSE);
  - the request enum (NONE/NEXT/PREV);
  - a helper function for index wrap.
- One natural sub-module: vga_frame_tick, covering the vsync register, polarity handling per VS_ACTIVE_LOW, edge detect, frame_tick output and frame_cnt.

Test Plan:
- Reset, then vsync active at cycle 10 -> sched_active=1 and pat_update at cycle 12; pattern_sel=0; frame_cnt=1.
- DWELL_FRAMES=3, no keys, 7 frames -> pattern_sel steps 0->1 after frame 4 and 1->2 after frame 7; each step has a single pat_update pulse.
- pattern_sel=0, key_prev mid-frame -> pattern_sel=7 two cycles after the next vsync; dwell restarts. key_next at 7 -> 0.
- key_next and key_prev in the same cycle -> no pending and no change. key_pause, then 10 frames -> pattern_sel constant. key_next while paused -> +1 at the next frame.
- rst asserted mid-frame with pending=NEXT and pattern_sel=5 -> all outputs reset asynchronously; the request is lost; IDLE until the next vsync.
- With VGA_SCHED_BLANK_EN and key_next at pattern 2 -> pattern_blank high for one frame; pattern_sel=3 and pattern_blank=0 at the following frame_tick+1.
